// File: rtl/joybus_device_responder.sv
// joybus_device_responder
// Device-side Joybus responder emulating a standard N64 controller on one
// open-drain line. It decodes host command bytes and answers 0x00 with an
// identity reply and 0x01 with a 32-bit button snapshot. All other commands
// are absorbed silently. The line is only ever pulled low (joy_oe=1).
//
// Optional feature macro: JOYBUS_RESET_CMD_EN
//   defined   : command 0xFF also gets the identity reply
//   undefined : 0xFF is treated like any unknown command
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle; after a reply, the line is ignored for 1 us
// RX_LOW  | counting the low part of a host bit
// RX_HIGH | counting the high part of a host bit (idle timeout)
// RX_STOP | command accepted; waiting for the host stop pulse
// TURN    | bus turnaround, line released for 2 us
// TX_LOW  | driving the low part of a reply bit
// TX_HIGH | releasing for the high part of a reply bit
// TX_STOP | driving the 2 us device stop pulse
// IGNORE  | absorbing an unwanted frame until the line stays high long enough

module joybus_device_responder #(
  parameter int US_CYCLES = 50,
  parameter int IDLE_US   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_in,
  output logic        joy_oe,
  input  logic [31:0] buttons,
  input  logic        pak_present,
  output logic        busy,
  output logic        poll_strobe,
  output logic        rx_error
);

  localparam int LIM  = IDLE_US * US_CYCLES;
  localparam int MAXC = (LIM > 3 * US_CYCLES) ? LIM : 3 * US_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_US1    = CW'(US_CYCLES);
  localparam logic [CW-1:0] C_US2    = CW'(2 * US_CYCLES);
  localparam logic [CW-1:0] C_US1_M1 = CW'(US_CYCLES - 1);
  localparam logic [CW-1:0] C_US2_M1 = CW'(2 * US_CYCLES - 1);
  localparam logic [CW-1:0] C_US3_M1 = CW'(3 * US_CYCLES - 1);
  localparam logic [CW-1:0] C_LIM_M1 = CW'(LIM - 1);

  typedef enum logic [3:0] {
    IDLE,
    RX_LOW,
    RX_HIGH,
    RX_STOP,
    TURN,
    TX_LOW,
    TX_HIGH,
    TX_STOP,
    IGNORE
  } state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          joy_s;
  logic [CW-1:0] cnt;
  logic [6:0]    rx_shift;
  logic [2:0]    rx_bits;
  logic          stop_low;
  logic [31:0]   tx_shift;
  logic [5:0]    tx_left;

  logic          rx_bit;
  logic [7:0]    rx_byte;
  logic          cmd_id;
  logic          cmd_poll;

  // Reply phase lengths minus one, loaded into the down-counter.
  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? C_US1_M1 : C_US3_M1;
  endfunction

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? C_US3_M1 : C_US1_M1;
  endfunction

  // Two-flop synchroniser; resets to the idle (high) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], joy_in};
  end

  assign joy_s = sync_q[1];

  // Bit classification on the low count and command decode of the byte.
  always_comb begin
    rx_bit   = (cnt < C_US2);
    rx_byte  = {rx_shift, rx_bit};
    cmd_poll = (rx_byte == 8'h01);
`ifdef JOYBUS_RESET_CMD_EN
    cmd_id   = (rx_byte == 8'h00) || (rx_byte == 8'hFF);
`else
    cmd_id   = (rx_byte == 8'h00);
`endif
  end

  // Main sequencer: receive, decode, turnaround, transmit, ignore.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_shift    <= '0;
      rx_bits     <= '0;
      stop_low    <= 1'b0;
      tx_shift    <= '0;
      tx_left     <= '0;
      joy_oe      <= 1'b0;
      busy        <= 1'b0;
      poll_strobe <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      poll_strobe <= 1'b0;
      rx_error    <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - C_ONE;
          end else if (!joy_s) begin
            state   <= RX_LOW;
            cnt     <= C_ONE;
            rx_bits <= '0;
            busy    <= 1'b1;
          end
        end

        RX_LOW: begin
          if (!joy_s) begin
            if (cnt >= C_LIM_M1) begin
              rx_error <= 1'b1;
              state    <= IGNORE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + C_ONE;
            end
          end else begin
            rx_shift <= rx_byte[6:0];
            rx_bits  <= rx_bits + 3'd1;
            cnt      <= C_ONE;
            if (rx_bits == 3'd7) begin
              stop_low <= 1'b0;
              if (cmd_id) begin
                tx_shift <= {8'h05, 8'h00, (pak_present ? 8'h01 : 8'h02), 8'h00};
                tx_left  <= 6'd24;
                state    <= RX_STOP;
              end else if (cmd_poll) begin
                tx_shift    <= buttons;
                tx_left     <= 6'd32;
                poll_strobe <= 1'b1;
                state       <= RX_STOP;
              end else begin
                state <= IGNORE;
              end
            end else begin
              state <= RX_HIGH;
            end
          end
        end

        RX_HIGH: begin
          if (!joy_s) begin
            state <= RX_LOW;
            cnt   <= C_ONE;
          end else if (cnt >= C_LIM_M1) begin
            rx_error <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end

        // A host that never sends its stop pulse is treated as a framing
        // error so the responder cannot stay busy forever.
        RX_STOP: begin
          if (!stop_low) begin
            if (!joy_s) begin
              stop_low <= 1'b1;
              cnt      <= C_ONE;
            end else if (cnt >= C_LIM_M1) begin
              rx_error <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + C_ONE;
            end
          end else if (!joy_s) begin
            if (cnt >= C_LIM_M1) begin
              rx_error <= 1'b1;
              state    <= IGNORE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + C_ONE;
            end
          end else begin
            state <= TURN;
            cnt   <= C_US2;
          end
        end

        TURN: begin
          if (!joy_s) begin
            rx_error <= 1'b1;
            state    <= IGNORE;
            cnt      <= '0;
          end else if (cnt == '0) begin
            state  <= TX_LOW;
            joy_oe <= 1'b1;
            cnt    <= low_len(tx_shift[31]);
          end else begin
            cnt <= cnt - C_ONE;
          end
        end

        TX_LOW: begin
          if (cnt == '0) begin
            joy_oe <= 1'b0;
            state  <= TX_HIGH;
            cnt    <= high_len(tx_shift[31]);
          end else begin
            cnt <= cnt - C_ONE;
          end
        end

        TX_HIGH: begin
          if (cnt == '0) begin
            joy_oe <= 1'b1;
            if (tx_left == 6'd1) begin
              state <= TX_STOP;
              cnt   <= C_US2_M1;
            end else begin
              tx_shift <= {tx_shift[30:0], 1'b0};
              tx_left  <= tx_left - 6'd1;
              state    <= TX_LOW;
              cnt      <= low_len(tx_shift[30]);
            end
          end else begin
            cnt <= cnt - C_ONE;
          end
        end

        // The 1 us hold-off in IDLE hides our own stop pulse still sitting
        // in the synchroniser.
        TX_STOP: begin
          if (cnt == '0) begin
            joy_oe <= 1'b0;
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= C_US1;
          end else begin
            cnt <= cnt - C_ONE;
          end
        end

        IGNORE: begin
          if (!joy_s) begin
            cnt <= '0;
          end else if (cnt >= C_LIM_M1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + C_ONE;
          end
        end

        default: begin
          state  <= IDLE;
          joy_oe <= 1'b0;
          busy   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_device_responder.sv
// Testbench for joybus_device_responder: a host model drives command
// frames on an open-drain line shared with the DUT; a monitor decodes the
// DUT's joy_oe pulses into replies and compares them against a queue of
// replies predicted from the command rules.

module tb_joybus_device_responder;

  localparam int US      = 4;
  localparam int IDLE_US = 8;
  localparam int LIM     = IDLE_US * US;

`ifdef JOYBUS_RESET_CMD_EN
  localparam bit RESET_EN = 1'b1;
`else
  localparam bit RESET_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  nbits;
  } reply_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_level;
  logic        joy_in;
  logic        joy_oe;
  logic [31:0] buttons;
  logic        pak_present;
  logic        busy;
  logic        poll_strobe;
  logic        rx_error;

  // Open-drain line: low if either side pulls it.
  assign joy_in = host_level & ~joy_oe;

  always #5 clk = ~clk;

  joybus_device_responder #(.US_CYCLES(US), .IDLE_US(IDLE_US)) dut (
    .clk(clk), .reset(reset), .joy_in(joy_in), .joy_oe(joy_oe),
    .buttons(buttons), .pak_present(pak_present), .busy(busy),
    .poll_strobe(poll_strobe), .rx_error(rx_error)
  );

  reply_t exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_replies = 0, n_oe_rises = 0, n_poll = 0, n_err = 0;

  int          mon_run = 0;
  int          mon_nb  = 0;
  logic        mon_prev = 1'b0;
  logic        mon_last = 1'b0;
  logic [31:0] mon_bits = '0;
  bit          mon_in  = 1'b0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: reply content as a function of command and latched inputs.
  function automatic bit model(input logic [7:0] cmd, input logic [31:0] btn,
                               input logic pak, output reply_t r);
    r.data  = '0;
    r.nbits = '0;
    if (cmd == 8'h00 || (RESET_EN && cmd == 8'hFF)) begin
      r.data  = {8'h00, 8'h05, 8'h00, (pak ? 8'h01 : 8'h02)};
      r.nbits = 6'd24;
      return 1'b1;
    end
    if (cmd == 8'h01) begin
      r.data  = btn;
      r.nbits = 6'd32;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (poll_strobe) n_poll++;
    if (rx_error)    n_err++;
  end

  // Monitor: decode joy_oe pulse widths into bits and whole replies.
  always @(negedge clk) begin
    if (reset) begin
      mon_prev = 1'b0; mon_run = 0; mon_nb = 0; mon_bits = '0; mon_in = 1'b0;
    end else if (joy_oe == mon_prev) begin
      mon_run++;
    end else begin
      if (mon_prev) begin
        check(mon_run == US || mon_run == 3*US || mon_run == 2*US,
              "tx_low_width", mon_run, US);
        if (mon_run == 2*US) begin
          n_replies++;
          check(exp_q.size() != 0, "unexpected_reply", mon_bits, 0);
          if (exp_q.size() != 0) begin
            reply_t e;
            e = exp_q.pop_front();
            check(mon_nb == int'(e.nbits), "reply_length", mon_nb, e.nbits);
            check(mon_bits == e.data, "reply_data", mon_bits, e.data);
          end
          mon_nb = 0; mon_bits = '0; mon_in = 1'b0;
        end else begin
          mon_last = (mon_run == US);
          mon_bits = {mon_bits[30:0], mon_last};
          mon_nb++;
        end
      end else begin
        n_oe_rises++;
        if (mon_in && mon_nb > 0)
          check(mon_run == (mon_last ? 3*US : US), "tx_high_width",
                mon_run, mon_last ? 3*US : US);
        mon_in = 1'b1;
      end
      mon_prev = joy_oe;
      mon_run  = 1;
    end
  end

  task automatic hold(input logic lvl, input int n);
    host_level = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: nominal host timing, 1: random legal timing, 2: threshold edges
  task automatic send_byte(input logic [7:0] b, input int mode);
    for (int i = 7; i >= 0; i--) begin
      logic bt;
      int lo, hi;
      bt = b[i];
      case (mode)
        0: begin lo = bt ? US : 3*US; hi = bt ? 3*US : US; end
        1: begin
          lo = bt ? int'($urandom_range(1, 2*US-1)) : int'($urandom_range(2*US, 4*US));
          hi = int'($urandom_range(1, 4*US));
        end
        default: begin lo = bt ? 2*US-1 : 2*US; hi = US; end
      endcase
      hold(1'b0, lo);
      hold(1'b1, hi);
    end
  endtask

  task automatic do_cmd(input logic [7:0] cmd, input int n_extra,
                        input int mode, input bit change_btn);
    reply_t r;
    bit has;
    int p0, e0, r0, o0, t;
    has = model(cmd, buttons, pak_present, r);
    if (has) exp_q.push_back(r);
    p0 = n_poll; e0 = n_err; r0 = n_replies; o0 = n_oe_rises;
    send_byte(cmd, mode);
    for (int k = 0; k < n_extra; k++) send_byte(8'($urandom), mode);
    hold(1'b0, US);
    host_level = 1'b1;
    if (has) begin
      t = 0;
      while (!joy_oe && t < 200) begin @(posedge clk); #1; t++; end
      // 2 sync + turnaround + 1 register, counted from the first edge
      // that samples the raised line (that edge itself counts as 1).
      check(t == (2 + 2*US + 1) + 1, "reply_latency", t, (2 + 2*US + 1) + 1);
      check(busy == 1'b1, "busy_in_reply", busy, 1);
      if (change_btn) begin
        repeat (3*US) @(posedge clk);
        #1;
        buttons = $urandom;
        pak_present = ~pak_present;
      end
      t = 0;
      while (n_replies == r0 && t < 3000) begin @(posedge clk); #1; t++; end
      check(n_replies == r0 + 1, "reply_done", n_replies - r0, 1);
      check(busy == 1'b0, "busy_after_reply", busy, 0);
    end else begin
      repeat (LIM + 8) @(posedge clk);
      #1;
      check(n_oe_rises == o0, "no_reply", n_oe_rises - o0, 0);
      check(busy == 1'b0, "busy_idle", busy, 0);
    end
    check(n_poll - p0 == ((has && cmd == 8'h01) ? 1 : 0), "poll_strobe_count",
          n_poll - p0, (has && cmd == 8'h01) ? 1 : 0);
    check(n_err == e0, "rx_error_none", n_err - e0, 0);
    hold(1'b1, 2*US);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got 0, required 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, o0, t;
    reply_t r;
    bit has;
    reset = 1'b1; host_level = 1'b1; buttons = '0; pak_present = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(joy_oe == 1'b0, "reset_joy_oe", joy_oe, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(poll_strobe == 1'b0, "reset_poll_strobe", poll_strobe, 0);
    check(rx_error == 1'b0, "reset_rx_error", rx_error, 0);
    reset = 1'b0;
    hold(1'b1, 2*US);

    // identity without pak, poll with mid-reply button change, absorbed read
    do_cmd(8'h00, 0, 0, 1'b0);
    buttons = 32'h8001_22F0;
    do_cmd(8'h01, 0, 0, 1'b1);
    do_cmd(8'h02, 2, 0, 1'b0);

    // line held low mid-byte
    e0 = n_err; o0 = n_oe_rises;
    hold(1'b0, US);   hold(1'b1, 3*US);
    hold(1'b0, 3*US); hold(1'b1, US);
    hold(1'b0, 40);
    hold(1'b1, LIM + 10);
    check(n_err - e0 == 1, "rx_error_pulse", n_err - e0, 1);
    check(n_oe_rises == o0, "no_reply_after_abort", n_oe_rises - o0, 0);
    check(busy == 1'b0, "busy_after_abort", busy, 0);
    buttons = $urandom;
    do_cmd(8'h01, 0, 0, 1'b0);

    // reset during the second reply byte
    pak_present = 1'b1;
    has = model(8'h00, buttons, pak_present, r);
    exp_q.push_back(r);
    send_byte(8'h00, 0);
    hold(1'b0, US);
    host_level = 1'b1;
    t = 0;
    while (!(mon_nb >= 9 && joy_oe) && t < 3000) begin @(posedge clk); #1; t++; end
    check(t < 3000, "reach_second_byte", t, 3000);
    #2 reset = 1'b1;
    #1;
    check(joy_oe == 1'b0, "async_reset_joy_oe", joy_oe, 0);
    check(busy == 1'b0, "async_reset_busy", busy, 0);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    hold(1'b1, 2*US);
    do_cmd(8'h00, 0, 0, 1'b0);

    // reset command, then exact classification thresholds
    do_cmd(8'hFF, 0, 0, 1'b0);
    buttons = $urandom;
    do_cmd(8'h01, 0, 2, 1'b0);
    do_cmd(8'h00, 0, 2, 1'b0);

    // randomized commands, timing and inputs
    for (int n = 0; n < 14; n++) begin
      logic [7:0] c;
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: c = 8'h00;
        1: c = 8'h01;
        2: c = 8'hFF;
        default: c = 8'($urandom);
      endcase
      buttons = $urandom;
      pak_present = 1'($urandom);
      do_cmd(c, (c > 8'h01 && c != 8'hFF) ? int'($urandom_range(0, 2)) : 0,
             1, 1'($urandom));
    end

    check(exp_q.size() == 0, "pending_replies", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/joybus_device_responder.md
# joybus_device_responder

Device-side (controller-end) Joybus responder: it sits on one open-drain joystick line and emulates a standard N64 controller answering the PIF-side controller master. It decodes pulse-width-encoded command bytes from the host, then replies with identity/status (0x00, optionally 0xFF) or a 32-bit button snapshot (0x01), driving the line low only. It is used for controller emulation and as a loop-back partner for the controller master in simulation.

## Interface
- US_CYCLES, 50, clock cycles per 1 µs Joybus time unit (minimum 4)
- IDLE_US, 8, high time in µs that marks the line idle or aborts a frame
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- joy_in  in  1  raw line level (unsynchronised)
- joy_oe  out  1  1 = pull line low; 0 = release (tri-state handled outside)
- buttons  in  32  live button/stick word, bit 31 sent first
- pak_present  in  1  selects the status byte of the identity reply
- busy  out  1  high from the first command falling edge until return to IDLE
- poll_strobe  out  1  one-cycle pulse when a 0x01 command is accepted
- rx_error  out  1  one-cycle pulse on a framing violation

## Operation
- joy_in passes through a 2-flop synchroniser, so every line edge is seen 2 cycles late. All timing below is measured on the synchronised level.
- The FSM has these states: IDLE, RX_LOW, RX_HIGH, RX_STOP, TURN, TX_LOW, TX_HIGH, TX_STOP, IGNORE.
- IDLE → RX_LOW on a low level. RX_LOW counts low cycles.
- On a rising edge, the bit is 1 if low_count < 2·US_CYCLES and 0 otherwise. The bit shifts in MSB first and the FSM goes to RX_HIGH.
- In RX_HIGH, a low level goes to RX_LOW. If the high lasts IDLE_US·US_CYCLES cycles before 8 bits are collected, rx_error pulses and the FSM returns to IDLE.
- Low lasting ≥ IDLE_US·US_CYCLES in any RX state: rx_error pulses, then the FSM waits for high and enters IGNORE.
- After 8 bits the byte is decoded:
  - 0x00 → reply 0x05, 0x00, then 0x01 if pak_present else 0x02.
  - 0x01 → reply buttons[31:0] and pulse poll_strobe.
  - Any other byte → IGNORE.
  - buttons and pak_present are latched at decode.
- RX_STOP waits for the host stop pulse, which is any low pulse shorter than the abort limit. Its rising edge enters TURN.
- TURN holds the line released for 2·US_CYCLES. If the line goes low during TURN, rx_error pulses and the FSM enters IGNORE.
- Transmit, MSB first:
  - A 0 bit is 3 µs low then 1 µs high; a 1 bit is 1 µs low then 3 µs high.
  - After the last bit, TX_STOP drives 2 µs low and releases. The FSM then returns to IDLE and ignores the line for 1 µs.
- IGNORE returns to IDLE after IDLE_US µs of continuous high. Multi-byte commands (pak read/write) are absorbed this way.
- reset forces joy_oe=0, busy=0, poll_strobe=0, rx_error=0, state IDLE, and clears the counters. Reset mid-transmit releases the line immediately (asynchronously).

## Timing
- joy_oe is registered. TX phase lengths are exact multiples of US_CYCLES with ±0 cycle error.
- The reply's first falling edge comes 2 (sync) + 2·US_CYCLES + 1 cycles after the host stop-bit rising edge on joy_in.
- poll_strobe fires on the cycle the 8th bit's rising edge is registered.
- Bit-classification threshold: exactly 2·US_CYCLES low cycles → 0; 2·US_CYCLES−1 → 1.
- Reply lengths are 24 bits (identity) and 32 bits (poll), each plus stop. busy stays high throughout.

## Configuration
- JOYBUS_RESET_CMD_EN:
  - Defined: command 0xFF is accepted and gets the same 3-byte identity reply as 0x00.
  - Undefined: 0xFF is treated as an unknown command and goes to IGNORE, with no reply.

## Test plan
All scenarios use US_CYCLES=4.
- Host sends 0x00 plus stop, pak_present=0 → joy_oe waveform decodes to 0x05, 0x00, 0x02, then 8 clk low stop. busy falls after release.
- Host sends 0x01 plus stop, buttons=0x8001_22F0 → reply decodes to 0x80, 0x01, 0x22, 0xF0. poll_strobe pulses once. Changing buttons mid-reply does not alter the reply.
- Host sends 0x02 plus 2 address bytes → no joy_oe assertion. After 32 clk of idle high, state is IDLE and busy=0.
- Host holds the line low 40 clk mid-byte → one rx_error pulse and no reply. After release and idle, a following 0x01 is answered normally.
- Assert reset during the 2nd reply byte → joy_oe=0 in the same cycle. After deassert, the next 0x00 is answered correctly.
- Host sends 0xFF plus stop → identity reply with JOYBUS_RESET_CMD_EN defined; no reply and return to IDLE without it.
